// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard sequencer.
// Enable vectors are ordered {pc, if_id, id_ex, ex_mem, mem_wb}.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for one source register.
// EX/MEM wins over MEM/WB; register 0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ex_rs_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_regwrite_i,
  output logic [1:0]       fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)) begin
      fwd_o = FWD_EXMEM;
    end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
      fwd_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes, data-memory freeze with timeout,
// load-use stall, branch flush, forwarding selects and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] ex_rs1_i,
  input  logic [REG_W-1:0] ex_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memtoreg_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic             mem_memtoreg_i,
  input  logic             mem_memwrite_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_regwrite_i,
  input  logic             branch_taken_i,
  input  logic             dmem_ack_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             dmem_req_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             mem_err_o,
  output logic [1:0]       state_o
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              err_q, err_d;

  logic [4:0] en_c;
  logic [1:0] fl_c;
  logic       req_c;
  logic [1:0] fwd_a_c, fwd_b_c;
  logic       mem_acc;
  logic       load_use;

  assign mem_acc  = mem_memtoreg_i | mem_memwrite_i;
  assign load_use = ex_memtoreg_i & ex_regwrite_i & (ex_rd_i != '0) &
                    ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    en_c    = EN_ALL;
    fl_c    = 2'b00;
    req_c   = 1'b0;
    case (state_q)
      RUN: begin
        req_c = mem_acc;
        if (mem_acc && !dmem_ack_i) begin
          en_c    = EN_NONE;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else if (branch_taken_i) begin
          fl_c = 2'b11;
        end else if (load_use) begin
          en_c[4] = 1'b0;
          en_c[3] = 1'b0;
          fl_c[0] = 1'b1;
        end
      end
      MEM_WAIT: begin
        req_c = 1'b1;
        en_c  = EN_NONE;
        if (dmem_ack_i) begin
          // EX was held during the freeze, so a pending branch flushes now.
          en_c    = EN_ALL;
          fl_c    = branch_taken_i ? 2'b11 : 2'b00;
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ERR: begin
        en_c  = EN_NONE;
        err_d = 1'b1;
      end
      default: begin
        en_c    = EN_NONE;
        state_d = RUN;
      end
    endcase
  end

  fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .ex_rs_i        (ex_rs1_i),
    .mem_rd_i       (mem_rd_i),
    .mem_regwrite_i (mem_regwrite_i),
    .wb_rd_i        (wb_rd_i),
    .wb_regwrite_i  (wb_regwrite_i),
    .fwd_o          (fwd_a_c)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .ex_rs_i        (ex_rs2_i),
    .mem_rd_i       (mem_rd_i),
    .mem_regwrite_i (mem_regwrite_i),
    .wb_rd_i        (wb_rd_i),
    .wb_regwrite_i  (wb_regwrite_i),
    .fwd_o          (fwd_b_c)
  );

  // Every control output is forced inactive while reset is held.
  assign pc_en_o       = rst_n & en_c[4];
  assign if_id_en_o    = rst_n & en_c[3];
  assign id_ex_en_o    = rst_n & en_c[2];
  assign ex_mem_en_o   = rst_n & en_c[1];
  assign mem_wb_en_o   = rst_n & en_c[0];
  assign if_id_flush_o = rst_n & fl_c[1];
  assign id_ex_flush_o = rst_n & fl_c[0];
  assign dmem_req_o    = rst_n & req_c;
  assign fwd_a_o       = rst_n ? fwd_a_c : FWD_RF;
  assign fwd_b_o       = rst_n ? fwd_b_c : FWD_RF;
  assign stall_cnt_o   = stall_q;
  assign mem_err_o     = err_q;
  assign state_o       = state_q;

  always_comb begin
    stall_d = stall_q;
    if (!pc_en_o && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

endmodule
